writeback_arbiter: RTL and testbench



---
 rtl/writeback_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges NUM_CH producer channels onto one register-file
// write port. Each channel has a small FIFO; a round-robin arbiter drains one
// write per cycle into a registered write port. Empty-FIFO inputs may bypass
// straight to the output register so a lone producer sees one cycle latency.
module writeback_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DROP_X0 = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic [NUM_CH-1:0]                             ch_valid_i,
  output logic [NUM_CH-1:0]                             ch_ready_o,
  input  logic [NUM_CH-1:0]                             ch_reg_write_i,
  input  logic [NUM_CH*ADDR_W-1:0]                      ch_reg_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]                      ch_reg_data_i,
  output logic                                          reg_write_o,
  output logic [ADDR_W-1:0]                             reg_addr_o,
  output logic [DATA_W-1:0]                             reg_data_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] reg_src_o,
  output logic                                          busy_o
);

  localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr_r [NUM_CH][DEPTH];
  logic [DATA_W-1:0] fifo_data_r [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r    [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_r    [NUM_CH];
  logic [CNT_W-1:0]  count_r     [NUM_CH];
  logic [SRC_W-1:0]  rr_r;

  // Per-channel combinational view
  logic [NUM_CH-1:0] ready_s;
  logic [NUM_CH-1:0] nonempty_s;
  logic [NUM_CH-1:0] keep_s;
  logic [NUM_CH-1:0] cand_s;
  logic [NUM_CH-1:0] grant_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [ADDR_W-1:0] in_addr_s   [NUM_CH];
  logic [DATA_W-1:0] in_data_s   [NUM_CH];
  logic [ADDR_W-1:0] cand_addr_s [NUM_CH];
  logic [DATA_W-1:0] cand_data_s [NUM_CH];

  // Arbitration result
  logic              win_found_s;
  logic [SRC_W-1:0]  win_idx_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  // Ready and busy depend on FIFO occupancy only, never on valid
  always_comb begin
    ready_s    = {NUM_CH{1'b0}};
    nonempty_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      ready_s[k]    = (count_r[k] < CNT_W'(DEPTH));
      nonempty_s[k] = (count_r[k] != {CNT_W{1'b0}});
    end
  end

  assign ch_ready_o = ready_s;
  assign busy_o     = |nonempty_s;

  // Input filtering and per-channel candidate selection (head first, else bypass)
  always_comb begin
    keep_s = {NUM_CH{1'b0}};
    cand_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      in_addr_s[k] = ch_reg_addr_i[k*ADDR_W +: ADDR_W];
      in_data_s[k] = ch_reg_data_i[k*DATA_W +: DATA_W];
      keep_s[k]    = ch_valid_i[k] & ready_s[k] & ch_reg_write_i[k] &
                     ~((DROP_X0 != 0) && (in_addr_s[k] == {ADDR_W{1'b0}}));
      cand_s[k]    = nonempty_s[k] | keep_s[k];
      if (nonempty_s[k]) begin
        cand_addr_s[k] = fifo_addr_r[k][rd_ptr_r[k]];
        cand_data_s[k] = fifo_data_r[k][rd_ptr_r[k]];
      end else begin
        cand_addr_s[k] = in_addr_s[k];
        cand_data_s[k] = in_data_s[k];
      end
    end
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    int idx_v;
    idx_v       = 0;
    win_found_s = 1'b0;
    win_idx_s   = {SRC_W{1'b0}};
    grant_s     = {NUM_CH{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_v = int'(rr_r) + i;
      if (idx_v >= NUM_CH) begin
        idx_v = idx_v - NUM_CH;
      end else begin
        idx_v = idx_v;
      end
      if (!win_found_s && cand_s[idx_v[SRC_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v[SRC_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
    if (win_found_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = {NUM_CH{1'b0}};
    end
  end

  assign win_addr_s = cand_addr_s[win_idx_s];
  assign win_data_s = cand_data_s[win_idx_s];

  // Push/pop decisions; a granted bypass never enters the FIFO, flush blocks all
  always_comb begin
    push_s = {NUM_CH{1'b0}};
    pop_s  = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      push_s[k] = keep_s[k] & ~(grant_s[k] & ~nonempty_s[k]) & ~flush_i;
      pop_s[k]  = grant_s[k] & nonempty_s[k] & ~flush_i;
    end
  end

  // FIFO pointers and counts; pointers wrap at DEPTH-1 so any depth works
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        count_r[k]  <= {CNT_W{1'b0}};
      end
    end else if (flush_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        count_r[k]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= (wr_ptr_r[k] == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                           : wr_ptr_r[k] + PTR_W'(1'b1);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= (rd_ptr_r[k] == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                           : rd_ptr_r[k] + PTR_W'(1'b1);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   count_r[k] <= count_r[k] + CNT_W'(1'b1);
          2'b01:   count_r[k] <= count_r[k] - CNT_W'(1'b1);
          default: count_r[k] <= count_r[k];
        endcase
      end
    end
  end

  // FIFO payload storage; contents are meaningless while count is zero
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push_s[k]) begin
        fifo_addr_r[k][wr_ptr_r[k]] <= in_addr_s[k];
        fifo_data_r[k][wr_ptr_r[k]] <= in_data_s[k];
      end
    end
  end

  // Round-robin pointer follows the winner; held on flush or idle cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r <= {SRC_W{1'b0}};
    end else if (win_found_s && !flush_i) begin
      rr_r <= win_idx_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Registered write port; address/data/source hold when no write is issued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_write_o <= 1'b0;
      reg_addr_o  <= {ADDR_W{1'b0}};
      reg_data_o  <= {DATA_W{1'b0}};
      reg_src_o   <= {SRC_W{1'b0}};
    end else if (flush_i) begin
      reg_write_o <= 1'b0;
    end else if (win_found_s) begin
      reg_write_o <= 1'b1;
      reg_addr_o  <= win_addr_s;
      reg_data_o  <= win_data_s;
      reg_src_o   <= win_idx_s;
    end else begin
      reg_write_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter (NUM_CH=2, DEPTH=2, DROP_X0=1): a vector
// table of cycle-exact expectations, a per-channel scoreboard of accepted
// writes, and hand-written stream and asynchronous-reset sequences.
module tb_writeback_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [1:0]  ch_valid_i;
  logic [1:0]  ch_ready_o;
  logic [1:0]  ch_reg_write_i;
  logic [9:0]  ch_reg_addr_i;
  logic [63:0] ch_reg_data_i;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic [0:0]  reg_src_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  // per-channel expected writes: {addr, data}
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];
  logic        last_src;

  typedef struct {
    logic        flush;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_src;
    logic        e_busy;
    logic [1:0]  e_ready;
  } vec_t;

  vec_t vecs [18];

  writeback_arbiter #(
    .NUM_CH(2), .DEPTH(2), .ADDR_W(5), .DATA_W(32), .DROP_X0(1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .ch_valid_i     (ch_valid_i),
    .ch_ready_o     (ch_ready_o),
    .ch_reg_write_i (ch_reg_write_i),
    .ch_reg_addr_i  (ch_reg_addr_i),
    .ch_reg_data_i  (ch_reg_data_i),
    .reg_write_o    (reg_write_o),
    .reg_addr_o     (reg_addr_o),
    .reg_data_o     (reg_data_o),
    .reg_src_o      (reg_src_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, record accepted writes, check port at posedge+1
  task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] w,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      output logic [1:0] acc);
    logic        exp_wr;
    logic [36:0] e;
    @(negedge clk_i);
    flush_i        = fl;
    ch_valid_i     = v;
    ch_reg_write_i = w;
    ch_reg_addr_i  = {a1, a0};
    ch_reg_data_i  = {d1, d0};
    acc = v & ch_ready_o;
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (acc[0] && w[0] && (a0 != 5'd0)) q0.push_back({a0, d0});
      if (acc[1] && w[1] && (a1 != 5'd0)) q1.push_back({a1, d1});
    end
    exp_wr = (q0.size() + q1.size()) > 0;
    @(posedge clk_i);
    #1;
    chk("sb_write", {31'd0, reg_write_o}, {31'd0, exp_wr});
    if (reg_write_o) begin
      if (reg_src_o == 1'b0) begin
        if (q1.size() > 0) chk("rr_fair", {31'd0, reg_src_o}, {31'd0, ~last_src});
        if (q0.size() == 0) begin
          chk("sb_unexpected_ch0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("sb_addr0", {27'd0, reg_addr_o}, {27'd0, e[36:32]});
          chk("sb_data0", reg_data_o, e[31:0]);
        end
      end else begin
        if (q0.size() > 0) chk("rr_fair", {31'd0, reg_src_o}, {31'd0, ~last_src});
        if (q1.size() == 0) begin
          chk("sb_unexpected_ch1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("sb_addr1", {27'd0, reg_addr_o}, {27'd0, e[36:32]});
          chk("sb_data1", reg_data_o, e[31:0]);
        end
      end
      last_src = reg_src_o[0];
    end
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    logic [1:0] acc;
    int n0, n1;
    logic saw_full;

    //          fl    valid  write  a0     d0            a1     d1          wr    addr   data          src   busy  ready
    vecs[0]  = '{1'b0, 2'b01, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,      1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 2'b11};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 2'b11};
    vecs[2]  = '{1'b0, 2'b11, 2'b11, 5'd1, 32'h11,       5'd2, 32'h22,     1'b1, 5'd2, 32'h22,       1'b1, 1'b1, 2'b11};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd1, 32'h11,       1'b0, 1'b0, 2'b11};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd1, 32'h11,       1'b0, 1'b0, 2'b11};
    vecs[5]  = '{1'b0, 2'b01, 2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,      1'b0, 5'd1, 32'h11,       1'b0, 1'b0, 2'b11};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 5'd7, 32'h77,       5'd0, 32'h0,      1'b0, 5'd1, 32'h11,       1'b0, 1'b0, 2'b11};
    vecs[7]  = '{1'b0, 2'b10, 2'b10, 5'd0, 32'h0,        5'd0, 32'h99,     1'b0, 5'd1, 32'h11,       1'b0, 1'b0, 2'b11};
    vecs[8]  = '{1'b0, 2'b11, 2'b11, 5'd3, 32'hA0,       5'd4, 32'hB0,     1'b1, 5'd4, 32'hB0,       1'b1, 1'b1, 2'b11};
    vecs[9]  = '{1'b0, 2'b11, 2'b11, 5'd3, 32'hA1,       5'd4, 32'hB1,     1'b1, 5'd3, 32'hA0,       1'b0, 1'b1, 2'b11};
    vecs[10] = '{1'b0, 2'b11, 2'b11, 5'd3, 32'hA2,       5'd4, 32'hB2,     1'b1, 5'd4, 32'hB1,       1'b1, 1'b1, 2'b10};
    vecs[11] = '{1'b0, 2'b11, 2'b11, 5'd3, 32'hA3,       5'd4, 32'hB3,     1'b1, 5'd3, 32'hA1,       1'b0, 1'b1, 2'b01};
    vecs[12] = '{1'b1, 2'b11, 2'b11, 5'd3, 32'hA5,       5'd4, 32'hB5,     1'b0, 5'd3, 32'hA1,       1'b0, 1'b0, 2'b11};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd3, 32'hA1,       1'b0, 1'b0, 2'b11};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd3, 32'hA1,       1'b0, 1'b0, 2'b11};
    vecs[15] = '{1'b0, 2'b11, 2'b11, 5'd6, 32'hC0,       5'd8, 32'hD0,     1'b1, 5'd8, 32'hD0,       1'b1, 1'b1, 2'b11};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd6, 32'hC0,       1'b0, 1'b0, 2'b11};
    vecs[17] = '{1'b0, 2'b00, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd6, 32'hC0,       1'b0, 1'b0, 2'b11};

    rst_ni = 1'b0;
    flush_i = 1'b0;
    ch_valid_i = 2'b00;
    ch_reg_write_i = 2'b00;
    ch_reg_addr_i = 10'd0;
    ch_reg_data_i = 64'd0;
    last_src = 1'b0;
    #7;
    chk("rst_write", {31'd0, reg_write_o}, 32'd0);
    chk("rst_addr",  {27'd0, reg_addr_o}, 32'd0);
    chk("rst_data",  reg_data_o, 32'd0);
    chk("rst_src",   {31'd0, reg_src_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {30'd0, ch_ready_o}, 32'd3);
    #1 rst_ni = 1'b1;

    // Cycle-exact vector table
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].flush, vecs[i].valid, vecs[i].write, vecs[i].a0, vecs[i].d0,
           vecs[i].a1, vecs[i].d1, acc);
      chk($sformatf("v%0d_write", i), {31'd0, reg_write_o}, {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_addr", i),  {27'd0, reg_addr_o},  {27'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_data", i),  reg_data_o,           vecs[i].e_data);
      chk($sformatf("v%0d_src", i),   {31'd0, reg_src_o},   {31'd0, vecs[i].e_src});
      chk($sformatf("v%0d_busy", i),  {31'd0, busy_o},      {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_ready", i), {30'd0, ch_ready_o},  {30'd0, vecs[i].e_ready});
    end

    // ch0 streams every cycle, ch1 offers three writes; scoreboard checks order/fairness
    n0 = 0;
    n1 = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, {(n1 < 3) ? 1'b1 : 1'b0, 1'b1}, 2'b11,
           5'd9, 32'h100 + 32'(n0), 5'd10, 32'h200 + 32'(n1), acc);
      if (acc[0]) n0++;
      if (acc[1]) n1++;
      if (!ch_ready_o[0]) saw_full = 1'b1;
    end
    idle(6);
    chk("stream_ch1_count", 32'(n1), 32'd3);
    chk("stream_ch0_ready_drop", {31'd0, saw_full}, 32'd1);
    chk("stream_drained", 32'(q0.size() + q1.size()), 32'd0);
    chk("stream_busy_idle", {31'd0, busy_o}, 32'd0);

    // Fill FIFOs, then reset asynchronously between edges
    step(1'b0, 2'b11, 2'b11, 5'd11, 32'hE0, 5'd12, 32'hF0, acc);
    step(1'b0, 2'b11, 2'b11, 5'd11, 32'hE1, 5'd12, 32'hF1, acc);
    step(1'b0, 2'b11, 2'b11, 5'd11, 32'hE2, 5'd12, 32'hF2, acc);
    chk("prereset_busy", {31'd0, busy_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_write", {31'd0, reg_write_o}, 32'd0);
    chk("arst_addr",  {27'd0, reg_addr_o}, 32'd0);
    chk("arst_data",  reg_data_o, 32'd0);
    chk("arst_src",   {31'd0, reg_src_o}, 32'd0);
    chk("arst_busy",  {31'd0, busy_o}, 32'd0);
    chk("arst_ready", {30'd0, ch_ready_o}, 32'd3);
    q0.delete();
    q1.delete();
    last_src = 1'b0;
    ch_valid_i = 2'b00;
    #2 rst_ni = 1'b1;
    idle(3);
    chk("postrst_busy", {31'd0, busy_o}, 32'd0);

    // After reset, a single write comes through with one-cycle latency
    step(1'b0, 2'b10, 2'b10, 5'd0, 32'd0, 5'd13, 32'h5A5A5A5A, acc);
    chk("postrst_src", {31'd0, reg_src_o}, 32'd1);
    chk("postrst_data", reg_data_o, 32'h5A5A5A5A);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
